pc_fetch_sequencer: RTL
=======================

// Module: pc_fetch_sequencer
// PURPOSE
//  Sequences the program counter and the instruction-memory fetch port for the single-cycle core.
//  Issues fetches at the current PC and tolerates variable memory latency via a req/ready handshake.
//  Applies redirects (branch/jump) and stall/halt requests, and vectors to a trap address on faults.
//  Sits between the PC register path and the IMEM port. It owns the only write path to the PC.
// PARAMETERS
//  RESET_VECTOR    32'h0000_0000  PC value loaded on reset
//  TRAP_VECTOR     32'h0000_0100  PC value loaded on a fetch fault
//  TIMEOUT_CYCLES  16             max cycles spent in WAIT before a timeout fault (>=1)
// PORTS
//  clk              in   1   system clock, all state on rising edge
//  reset            in   1   synchronous, active-high reset
//  stall            in   1   suppress issuing a new fetch; does not abort an outstanding one
//  redirect_valid   in   1   branch/jump taken this cycle
//  redirect_target  in   32  new PC for the redirect
//  halt_req         in   1   request entry to HALT
//  resume           in   1   leave HALT
//  imem_req         out  1   fetch request, combinational from state
//  imem_addr        out  32  fetch address; always equals pc_current
//  imem_ready       in   1   memory accepts and completes the fetch this cycle
//  imem_rdata       in   32  instruction word, valid when imem_req&&imem_ready
//  instr_out        out  32  delivered instruction
//  instr_pc         out  32  PC of instr_out
//  instr_valid      out  1   one-cycle pulse: instr_out/instr_pc are valid
//  pc_current       out  32  current PC register value
//  fault            out  1   one-cycle fault pulse
//  fault_cause      out  2   01 = misaligned redirect, 10 = fetch timeout; holds last cause
//  halted           out  1   high while in HALT
// BEHAVIOUR
//  - Reset: state=IDLE, pc=RESET_VECTOR, and pending redirect, halt_pending and timeout count cleared.
//    The reset values of instr_valid, fault and halted are 0, and fault_cause=00. instr_out and instr_pc reset to 0.
//  - Reset mid-transaction abandons the fetch. No instr_valid is produced for it.
//  - IDLE: one hold-off cycle, then go to REQ unconditionally.
//  - REQ: imem_req = !stall && !halt_req.
//    - halt_req high -> HALT next cycle.
//    - imem_req&&imem_ready -> complete (below), stay in REQ.
//    - imem_req&&!imem_ready -> WAIT.
//  - WAIT: imem_req=1 and the counter increments each cycle. imem_ready completes the fetch and returns to REQ.
//    - halt_req in WAIT sets halt_pending. The fetch still completes and is delivered, then the state goes to HALT.
//  - Completion at cycle N produces, at N+1: instr_valid=1, instr_out=imem_rdata, instr_pc=old pc, and pc=pc+4.
//    - The 32-bit add wraps: 32'hFFFF_FFFC -> 0.
//    - The fetch is killed (instr_valid stays 0) when redirect_valid is high at N or a redirect is pending.
//      In that case pc=target.
//  - Redirect outside a completion cycle:
//    - In REQ or HALT: pc=target next cycle.
//    - In WAIT: latched as pending; a later redirect overwrites it (last wins).
//  - Misaligned target (target[1:0]!=0) -> no redirect is applied. Instead:
//    - fault=1 for one cycle, fault_cause=01, pc=TRAP_VECTOR.
//    - If outstanding, the fetch is killed.
//  - Timeout: counter reaches TIMEOUT_CYCLES in WAIT without ready -> fault=1, fault_cause=10, pc=TRAP_VECTOR.
//    The pending redirect is cleared and the state goes to REQ. The counter clears on every WAIT exit.
//  - Priority within a cycle: reset > timeout > misaligned redirect > redirect > halt > sequential.
//  - HALT: imem_req=0, halted=1. resume -> REQ next cycle. If halt_req and resume are both high, stay in HALT.
//  - pc changes only as listed above. stall never changes pc.
// TESTING
//  1. Reset, then imem_ready tied 1 -> fetch addrs 0,4,8,...; instr_valid on consecutive cycles; instr_pc matches addr.
//  2. ready delayed 3 cycles with redirect to 0x40 in WAIT -> that fetch killed, next imem_addr=0x40.
//  3. Redirect to 0x42 -> fault pulse, fault_cause=01, next imem_addr=0x100.
//  4. imem_ready held 0 -> fault after 16 WAIT cycles, cause=10, pc=0x100, imem_req re-asserts in REQ.
//  5. halt_req during WAIT -> pending instr delivered, then halted=1, imem_req=0; resume -> fetch at pc+4.
//  6. pc=0xFFFF_FFFC, one completion -> pc=0; reset asserted mid-WAIT -> pc=0, no instr_valid.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// PC sequencer and instruction-memory fetch port for the single-cycle core.
// Owns the only write path to the PC; handles redirects, halts, misalignment and fetch timeouts.
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        halt_req,
   input  logic        resume,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   output logic [31:0] pc_current,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        halted
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HALT
   } state_t;

   state_t            state, state_n;
   logic [XLEN-1:0]   pc, pc_n;
   logic              redir_pend, redir_pend_n;
   logic [XLEN-1:0]   redir_tgt, redir_tgt_n;
   logic              halt_pend, halt_pend_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              valid_n;
   logic [XLEN-1:0]   instr_out_n, instr_pc_n;
   logic              fault_n;
   logic [1:0]        cause_n;
   logic              req_c;
   logic              redir_ok, redir_bad;

   assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
   assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

   assign imem_req   = req_c;
   assign imem_addr  = pc;
   assign pc_current = pc;

   // State register and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         pc          <= RESET_VECTOR;
         redir_pend  <= 1'b0;
         redir_tgt   <= '0;
         halt_pend   <= 1'b0;
         cnt         <= '0;
         instr_valid <= 1'b0;
         instr_out   <= '0;
         instr_pc    <= '0;
         fault       <= 1'b0;
         fault_cause <= 2'b00;
         halted      <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         redir_pend  <= redir_pend_n;
         redir_tgt   <= redir_tgt_n;
         halt_pend   <= halt_pend_n;
         cnt         <= cnt_n;
         instr_valid <= valid_n;
         instr_out   <= instr_out_n;
         instr_pc    <= instr_pc_n;
         fault       <= fault_n;
         fault_cause <= cause_n;
         halted      <= (state_n == S_HALT);
      end
   end

   // Next-state, PC update and fetch request
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      redir_pend_n = redir_pend;
      redir_tgt_n  = redir_tgt;
      halt_pend_n  = halt_pend;
      cnt_n        = cnt;
      valid_n      = 1'b0;
      instr_out_n  = instr_out;
      instr_pc_n   = instr_pc;
      fault_n      = 1'b0;
      cause_n      = fault_cause;
      req_c        = 1'b0;

      unique case (state)
         S_IDLE: begin
            state_n = S_REQ;
         end

         S_REQ: begin
            req_c = !stall && !halt_req;
            if (redir_bad) begin
               fault_n = 1'b1;
               cause_n = CAUSE_MISALIGN;
               pc_n    = TRAP_VECTOR;
            end else if (redir_ok) begin
               pc_n = redirect_target;
            end else if (req_c && imem_ready) begin
               valid_n     = 1'b1;
               instr_out_n = imem_rdata;
               instr_pc_n  = pc;
               pc_n        = pc + 32'd4;
            end
            // A redirect drops the un-accepted request; it re-issues at the new PC
            if (halt_req) begin
               state_n = S_HALT;
            end else if (req_c && !imem_ready && !redirect_valid) begin
               state_n = S_WAIT;
               cnt_n   = '0;
            end
         end

         S_WAIT: begin
            req_c = 1'b1;
            if (imem_ready) begin
               if (redir_bad) begin
                  fault_n = 1'b1;
                  cause_n = CAUSE_MISALIGN;
                  pc_n    = TRAP_VECTOR;
               end else if (redir_ok) begin
                  pc_n = redirect_target;
               end else if (redir_pend) begin
                  pc_n = redir_tgt;
               end else begin
                  valid_n     = 1'b1;
                  instr_out_n = imem_rdata;
                  instr_pc_n  = pc;
                  pc_n        = pc + 32'd4;
               end
               state_n      = (halt_pend || halt_req) ? S_HALT : S_REQ;
               redir_pend_n = 1'b0;
               halt_pend_n  = 1'b0;
               cnt_n        = '0;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               fault_n      = 1'b1;
               cause_n      = CAUSE_TIMEOUT;
               pc_n         = TRAP_VECTOR;
               state_n      = S_REQ;
               redir_pend_n = 1'b0;
               halt_pend_n  = 1'b0;
               cnt_n        = '0;
            end else if (redir_bad) begin
               fault_n      = 1'b1;
               cause_n      = CAUSE_MISALIGN;
               pc_n         = TRAP_VECTOR;
               state_n      = S_REQ;
               redir_pend_n = 1'b0;
               halt_pend_n  = 1'b0;
               cnt_n        = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
               if (redir_ok) begin
                  redir_pend_n = 1'b1;
                  redir_tgt_n  = redirect_target;
               end
               if (halt_req) begin
                  halt_pend_n = 1'b1;
               end
            end
         end

         S_HALT: begin
            if (redir_bad) begin
               fault_n = 1'b1;
               cause_n = CAUSE_MISALIGN;
               pc_n    = TRAP_VECTOR;
            end else if (redir_ok) begin
               pc_n = redirect_target;
            end
            if (resume && !halt_req) begin
               state_n = S_REQ;
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule
